// File: rtl/nios2_system_led_pio.sv
// Avalon-MM LED PIO: an 8-bit output register with set/clear/toggle ports and a
// per-bit blink overlay driven by a free-running prescaler.
module nios2_system_led_pio #(
    parameter logic [7:0] RESET_VALUE = 8'h00,
    parameter int         BLINK_DIV   = 25000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  out_port
);

    localparam int PW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(BLINK_DIV - 1);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_STATUS   = 3'd2;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
    localparam logic [2:0] ADDR_TOGGLE   = 3'd6;

    logic [7:0]    out_data_reg,  out_data_next;
    logic [7:0]    blink_en_reg,  blink_en_next;
    logic [PW-1:0] prescaler_reg, prescaler_next;
    logic          phase_reg,     phase_next;
    logic [31:0]   readdata_reg,  readdata_next;

    logic       wr_en;
    logic       wrap;
    logic [7:0] wr_byte;
    logic       unused_ok;

    assign wr_en     = chipselect & ~write_n;
    assign wr_byte   = writedata[7:0];
    assign wrap      = (prescaler_reg == PRESCALE_LAST);
    assign unused_ok = &{1'b0, writedata[31:8]};

    always_comb begin
        out_data_next  = out_data_reg;
        blink_en_next  = blink_en_reg;
        prescaler_next = wrap ? '0 : prescaler_reg + PW'(1);
        phase_next     = phase_reg ^ wrap;

        if (wr_en) begin
            case (address)
                ADDR_DATA:     out_data_next = wr_byte;
                ADDR_OUTSET:   out_data_next = out_data_reg | wr_byte;
                ADDR_OUTCLEAR: out_data_next = out_data_reg & ~wr_byte;
                ADDR_TOGGLE:   out_data_next = out_data_reg ^ wr_byte;
                ADDR_BLINK_EN: begin
                    // Restarting the blink cycle overrides a wrap on the same edge.
                    blink_en_next  = wr_byte;
                    prescaler_next = '0;
                    phase_next     = 1'b0;
                end
                default: ;
            endcase
        end

        // Read data reflects the registers before this edge's write.
        readdata_next = 32'h0;
        case (address)
            ADDR_DATA:     readdata_next = {24'h0, out_data_reg};
            ADDR_BLINK_EN: readdata_next = {24'h0, blink_en_reg};
            ADDR_STATUS:   readdata_next = {31'h0, phase_reg};
            default:       readdata_next = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_reg  <= RESET_VALUE;
            blink_en_reg  <= 8'h00;
            prescaler_reg <= '0;
            phase_reg     <= 1'b0;
            readdata_reg  <= 32'h0;
        end else begin
            out_data_reg  <= out_data_next;
            blink_en_reg  <= blink_en_next;
            prescaler_reg <= prescaler_next;
            phase_reg     <= phase_next;
            readdata_reg  <= readdata_next;
        end
    end

    assign readdata = readdata_reg;
    assign out_port = out_data_reg ^ (blink_en_reg & {8{phase_reg}});

endmodule

// File: tb/tb_nios2_system_led_pio.sv
// Directed bench for nios2_system_led_pio with BLINK_DIV=4, RESET_VALUE=8'h00.
module tb_nios2_system_led_pio;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int n_vec = 0;
    int n_err = 0;

    nios2_system_led_pio #(
        .RESET_VALUE(8'h00),
        .BLINK_DIV  (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    // Present a read address for one edge; readdata is then valid.
    task automatic rd(input logic [2:0] a);
        address = a;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (out_port !== 8'h00) begin
            n_err++;
            $display("FAIL reset_out_port: got %h expected %h", out_port, 8'h00);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd(3'(i));
            n_vec++;
            if (readdata !== 32'h0) begin
                n_err++;
                $display("FAIL reset_read_addr%0d: got %h expected %h", i, readdata, 32'h0);
            end
        end
        n_vec++;
        if (out_port !== 8'h00) begin
            n_err++;
            $display("FAIL reset_out_port_after: got %h expected %h", out_port, 8'h00);
        end
    endtask

    task automatic test_data_ops();
        logic [2:0]  addrs [4] = '{3'd0, 3'd4, 3'd5, 3'd6};
        logic [31:0] datas [4] = '{32'hFFFF_FF5A, 32'h81, 32'h0A, 32'hF0};
        logic [31:0] expct [4] = '{32'h5A, 32'hDB, 32'hD1, 32'h21};
        for (int i = 0; i < 4; i++) begin
            wr(addrs[i], datas[i]);
            rd(3'd0);
            n_vec++;
            if (readdata !== expct[i] || out_port !== expct[i][7:0]) begin
                n_err++;
                $display("FAIL data_op%0d: got rd=%h port=%h expected %h", i, readdata, out_port, expct[i]);
            end
            $display("data op %0d addr=%0d wd=%h -> rd=%h port=%h", i, addrs[i], datas[i], readdata, out_port);
        end
    endtask

    task automatic test_blink();
        logic [7:0] exp_port;
        wr(3'd0, 32'h0F);
        address = 3'd2;
        wr(3'd1, 32'hFF);
        address = 3'd2;
        for (int i = 0; i < 16; i++) begin
            exp_port = (((i / 4) % 2) == 1) ? 8'hF0 : 8'h0F;
            n_vec++;
            if (out_port !== exp_port) begin
                n_err++;
                $display("FAIL blink_port_cyc%0d: got %h expected %h", i, out_port, exp_port);
            end
            if (i >= 1) begin
                n_vec++;
                if (readdata !== {31'h0, 1'(((i - 1) / 4) % 2)}) begin
                    n_err++;
                    $display("FAIL blink_status_cyc%0d: got %h expected %h", i, readdata,
                             {31'h0, 1'(((i - 1) / 4) % 2)});
                end
            end
            @(negedge clk);
        end
        rd(3'd1);
        n_vec++;
        if (readdata !== 32'hFF) begin
            n_err++;
            $display("FAIL blink_en_read: got %h expected %h", readdata, 32'hFF);
        end
    endtask

    task automatic test_write_on_wrap();
        logic [7:0] exp_port;
        wr(3'd1, 32'hFF);
        repeat (3) @(negedge clk);
        // Prescaler now holds 3; this write lands on the wrap edge.
        wr(3'd1, 32'hFF);
        for (int j = 0; j < 8; j++) begin
            exp_port = (j < 4) ? 8'h0F : 8'hF0;
            n_vec++;
            if (out_port !== exp_port) begin
                n_err++;
                $display("FAIL wrap_write_cyc%0d: got %h expected %h", j, out_port, exp_port);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_no_effect();
        wr(3'd1, 32'h00);
        wr(3'd0, 32'h3C);
        address = 3'd0; writedata = 32'hFF; chipselect = 1'b0; write_n = 1'b0;
        @(negedge clk);
        write_n = 1'b1;
        wr(3'd3, 32'hFF);
        wr(3'd7, 32'hFF);
        rd(3'd0);
        n_vec++;
        if (readdata !== 32'h3C || out_port !== 8'h3C) begin
            n_err++;
            $display("FAIL ignored_writes_data: got rd=%h port=%h expected %h", readdata, out_port, 8'h3C);
        end
        rd(3'd1);
        n_vec++;
        if (readdata !== 32'h0) begin
            n_err++;
            $display("FAIL ignored_writes_blink: got %h expected %h", readdata, 32'h0);
        end
        rd(3'd7);
        n_vec++;
        if (readdata !== 32'h0) begin
            n_err++;
            $display("FAIL unmapped_read: got %h expected %h", readdata, 32'h0);
        end
        wr(3'd1, 32'hFF);
        wr(3'd2, 32'hFFFF_FFFF);
        rd(3'd2);
        n_vec++;
        if (readdata !== 32'h0 || out_port !== 8'h3C) begin
            n_err++;
            $display("FAIL status_write: got rd=%h port=%h expected rd=0 port=3c", readdata, out_port);
        end
        address = 3'd0; writedata = 32'h33; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        n_vec++;
        if (readdata !== 32'h3C) begin
            n_err++;
            $display("FAIL read_during_write_old: got %h expected %h", readdata, 32'h3C);
        end
        @(negedge clk);
        n_vec++;
        if (readdata !== 32'h33) begin
            n_err++;
            $display("FAIL read_during_write_new: got %h expected %h", readdata, 32'h33);
        end
    endtask

    task automatic test_async_reset();
        wr(3'd0, 32'hAA);
        wr(3'd1, 32'hFF);
        address = 3'd0;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if (out_port !== 8'h00 || readdata !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset: got port=%h rd=%h expected port=00 rd=0", out_port, readdata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        wr(3'd0, 32'h55);
        rd(3'd0);
        n_vec++;
        if (readdata !== 32'h55 || out_port !== 8'h55) begin
            n_err++;
            $display("FAIL first_write_after_reset: got rd=%h port=%h expected %h", readdata, out_port, 8'h55);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        test_reset();
        test_data_ops();
        test_blink();
        test_write_on_wrap();
        test_no_effect();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
